vga_spectrum_ctrl: RTL
======================

VGA_SPECTRUM_CTRL -- requirements
Module: vga_spectrum_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUM_BINS, 32, spectrum bars per frame.
REQ-002 BAR_W, 20, bar width in pixels; NUM_BINS*BAR_W = 640.
REQ-003 V_ACTIVE, 480, visible lines and maximum bar height.
REQ-004 BAR_RGB, 12'h0F4, bar colour (4:4:4).
REQ-005 BG_RGB, 12'h000, background colour.
REQ-006 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, single 25 MHz pixel clock; all logic on rising edge.
REQ-007 resetn, in, 1, synchronous active-low reset.
REQ-008 bin_valid, in, 1, spectrum bin offered.
REQ-009 bin_ready, out, 1, bin accepted when bin_valid and bin_ready are both high.
REQ-010 bin_data, in, 9, bar height in pixels, unsigned.
REQ-011 bin_last, in, 1, final bin of a spectrum packet.
REQ-012 row, in, 10, line index from the sync generator.
REQ-013 col, in, 10, pixel index from the sync generator.
REQ-014 data_enable, in, 1, active-video qualifier from the sync generator.
REQ-015 hsync_in and vsync_in, in, 1 each, sync pulses from the sync generator.
REQ-016 frame_pulse, in, 1, one-cycle pulse at start of vertical blanking.
REQ-017 pixel_rgb, out, 12, registered pixel colour.
REQ-018 hsync_out, vsync_out and de_out, out, 1 each, sync signals and data_enable delayed to align with pixel_rgb.
REQ-019 seq_err, out, 1, sticky packet-framing error flag.

Function
REQ-020 Storage SHALL be two banks of NUM_BINS 9-bit heights: a write bank and a display bank, selected by a bank-select bit.
REQ-021 On each accepted bin, the height SHALL be written to write_bank[wr_idx], clamped to V_ACTIVE if larger, and wr_idx SHALL increment.
REQ-022 A packet SHALL end when bin_last is accepted, or when bin NUM_BINS-1 is accepted.
REQ-023 At packet end, wr_idx SHALL return to 0 and pending SHALL be set on the next cycle.
REQ-024 seq_err SHALL set if bin_last arrives with wr_idx != NUM_BINS-1, or if bin NUM_BINS-1 is accepted without bin_last.
REQ-025 bin_ready SHALL equal not pending; no bins are accepted while a completed packet awaits its swap.
REQ-026 When frame_pulse is seen with pending already set, the banks SHALL swap and pending SHALL clear; bin_ready rises the cycle after the swap.
REQ-027 If the packet ends in the same cycle as frame_pulse, that pulse SHALL NOT swap; the swap SHALL occur at the next frame_pulse.
REQ-028 A frame_pulse without pending SHALL leave the banks unchanged, so the previous spectrum is redisplayed.
REQ-029 The display bank SHALL change only at a swap, so a frame is never torn.
REQ-030 Pixel path, latency exactly 1 cycle: bin index = floor(col/BAR_W); the pixel is lit iff data_enable and row >= V_ACTIVE - display_bank[bin index].
REQ-031 pixel_rgb SHALL be BAR_RGB when lit, otherwise BG_RGB; it SHALL be forced to 0 when data_enable is low.
REQ-032 hsync_out, vsync_out and de_out SHALL be the corresponding inputs registered once.
REQ-033 A height of 0 SHALL light no pixels; a height of V_ACTIVE SHALL light the full column.

Reset
REQ-034 While resetn is low at a clock edge: both banks all zero, bank-select 0, wr_idx 0, pending 0, seq_err 0, bin_ready 0.
REQ-035 After reset, bin_ready SHALL be 1 from the first cycle with resetn high.
REQ-036 While resetn is low at a clock edge, pixel_rgb, hsync_out, vsync_out and de_out SHALL be 0.
REQ-037 Reset mid-packet SHALL discard partial data; no swap occurs.

Structure
REQ-038 Shared package SHALL hold H_ACTIVE=640, V_ACTIVE=480, the RGB width (12) and the colour constants.
REQ-039 The bin-storage double buffer SHALL be one sub-module, spectrum_bank_buf (write port, display read port, swap input).
REQ-040 Pixel compare and packet sequencing SHALL live in the top module.

Verification
REQ-041 Reset, then 32 bins at height 100 with last on bin 31, then frame_pulse -> at next frame, col 0-639 lit for rows 380-479 only; seq_err=0.
REQ-042 Packet completes, no frame_pulse for 50 cycles -> bin_ready=0 throughout; bin_valid ignored; banks unchanged.
REQ-043 bin_last on bin 10 -> seq_err=1; swap still occurs at the next frame_pulse.
REQ-044 Final bin accepted in the same cycle as frame_pulse -> no swap that frame; swap at the following pulse.
REQ-045 bin_data=500 on bin 5 -> cols 100-119 lit for rows 0-479.
REQ-046 resetn low mid-packet (bin 15) -> after release: all pixels BG, seq_err=0, a fresh 32-bin packet displays correctly.

Source files
------------

// File: rtl/vga_spectrum_ctrl_pkg.sv
// vga_spectrum_ctrl_pkg: shared display geometry, colour constants and height helpers.
// Rev 1.0
`default_nettype none

package vga_spectrum_ctrl_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int RGB_W    = 12;
  localparam int HEIGHT_W = 9;

  localparam logic [RGB_W-1:0] BAR_RGB_DEF = 12'h0F4;
  localparam logic [RGB_W-1:0] BG_RGB_DEF  = 12'h000;

  typedef logic [HEIGHT_W-1:0] height_t;

  function automatic height_t clamp_height(input height_t h, input height_t limit);
    return (h > limit) ? limit : h;
  endfunction
endpackage

`default_nettype wire

// File: rtl/spectrum_bank_buf.sv
// spectrum_bank_buf: double-buffered bar heights; writes go to the hidden bank, reads see the shown one.
// Rev 1.0
`default_nettype none

module spectrum_bank_buf
  import vga_spectrum_ctrl_pkg::*;
#(
  parameter int NUM_BINS = 32,
  parameter int IDX_W    = $clog2(NUM_BINS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  height_t          wr_data_i,
  input  logic             swap_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output height_t          rd_data_o
);

  height_t bank_q [2][NUM_BINS];
  logic    sel_q;  // index of the bank currently on display

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_BINS; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      if (wr_en_i) begin
        bank_q[~sel_q][wr_idx_i] <= wr_data_i;
      end
      if (swap_i) begin
        sel_q <= ~sel_q;
      end
    end
  end

  assign rd_data_o = bank_q[sel_q][rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/vga_spectrum_ctrl.sv
// vga_spectrum_ctrl: packet sequencing of spectrum bins and 1-cycle bar-graph pixel generation.
// Rev 1.0
`default_nettype none

module vga_spectrum_ctrl #(
  parameter int          NUM_BINS = 32,
  parameter int          BAR_W    = 20,
  parameter int          V_ACTIVE = vga_spectrum_ctrl_pkg::V_ACTIVE,
  parameter logic [11:0] BAR_RGB  = vga_spectrum_ctrl_pkg::BAR_RGB_DEF,
  parameter logic [11:0] BG_RGB   = vga_spectrum_ctrl_pkg::BG_RGB_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        bin_valid,
  output logic        bin_ready,
  input  logic [8:0]  bin_data,
  input  logic        bin_last,
  input  logic [9:0]  row,
  input  logic [9:0]  col,
  input  logic        data_enable,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_pulse,
  output logic [11:0] pixel_rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic        seq_err
);
  import vga_spectrum_ctrl_pkg::*;

  localparam int             IDX_W    = $clog2(NUM_BINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             pending_q, pending_d;
  logic             seq_err_q, seq_err_d;
  logic             ready_q;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, vs_q, de_q;

  logic             w_accept, w_at_last, w_pkt_end, w_swap, w_lit;
  logic [9:0]       w_bin_col, w_threshold;
  height_t          w_rd_height;

  always_comb begin
    w_accept  = bin_valid & ready_q;
    w_at_last = (wr_idx_q == LAST_IDX);
    w_pkt_end = w_accept & (bin_last | w_at_last);
    // pending_q (not pending_d) gates the swap, so a packet ending on the pulse waits a frame
    w_swap    = frame_pulse & pending_q;

    wr_idx_d  = wr_idx_q;
    pending_d = pending_q;
    seq_err_d = seq_err_q;
    if (w_accept) begin
      wr_idx_d = w_pkt_end ? '0 : wr_idx_q + 1'b1;
      if (bin_last != w_at_last) begin
        seq_err_d = 1'b1;
      end
    end
    if (w_swap) begin
      pending_d = 1'b0;
    end else if (w_pkt_end) begin
      pending_d = 1'b1;
    end
  end

  spectrum_bank_buf #(
    .NUM_BINS (NUM_BINS),
    .IDX_W    (IDX_W)
  ) u_bank_buf (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en_i   (w_accept),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (clamp_height(bin_data, HEIGHT_W'(V_ACTIVE))),
    .swap_i    (w_swap),
    .rd_idx_i  (w_bin_col[IDX_W-1:0]),
    .rd_data_o (w_rd_height)
  );

  always_comb begin
    w_bin_col   = col / 10'(BAR_W);
    w_threshold = 10'(V_ACTIVE) - {1'b0, w_rd_height};
    w_lit       = data_enable && (w_bin_col < 10'(NUM_BINS)) && (row >= w_threshold);
    rgb_d       = !data_enable ? '0 : (w_lit ? BAR_RGB : BG_RGB);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_idx_q  <= '0;
      pending_q <= 1'b0;
      seq_err_q <= 1'b0;
      ready_q   <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      pending_q <= pending_d;
      seq_err_q <= seq_err_d;
      ready_q   <= ~pending_d;
      rgb_q     <= rgb_d;
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
      de_q      <= data_enable;
    end
  end

  assign bin_ready = ready_q;
  assign seq_err   = seq_err_q;
  assign pixel_rgb = rgb_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign de_out    = de_q;

endmodule

`default_nettype wire
